// File: rtl/rx_delay_meter_if.sv
// MAC RX byte-stream bundle: data byte, frame-valid and end-of-frame status pulses.
interface rx_delay_meter_if;
    logic [7:0] mac_rx_data;
    logic       mac_rx_dvld;
    logic       mac_rx_goodframe;
    logic       mac_rx_badframe;

    modport master (output mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe);
    modport slave  (input  mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe);
endinterface

// File: rtl/rx_delay_meter.sv
// Parses received test frames, reports one-way delay (SOF time - TX timestamp)
// and keeps saturating good/bad/timeout frame counters.
module rx_delay_meter #(
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    parameter int unsigned TS_OFFSET      = 14,
    parameter int unsigned SEQ_OFFSET     = 18,
    parameter int unsigned MIN_LEN        = 20,
    parameter int unsigned STATUS_TIMEOUT = 16
) (
    input  logic            rx_clk,
    input  logic            reset,
    input  logic [31:0]     now_time,
    rx_delay_meter_if.slave mac,
    output logic            delay_valid,
    output logic [31:0]     delay_value,
    output logic [15:0]     delay_seq,
    output logic [15:0]     good_count,
    output logic [15:0]     bad_count,
    output logic [15:0]     timeout_count
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_DATA,
        ST_WAIT_STATUS,
        ST_REPORT
    } state_t;

    localparam int unsigned      TMO_W    = $clog2(STATUS_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STATUS_TIMEOUT - 1);
    localparam logic [10:0]      IDX_MAX  = '1;
    localparam logic [10:0]      ETH_LO   = 11'd12;
    localparam logic [10:0]      ETH_HI   = 11'd14;
    localparam logic [10:0]      TS_LO    = 11'(TS_OFFSET);
    localparam logic [10:0]      TS_HI    = 11'(TS_OFFSET + 4);
    localparam logic [10:0]      SEQ_LO   = 11'(SEQ_OFFSET);
    localparam logic [10:0]      SEQ_HI   = 11'(SEQ_OFFSET + 2);
    localparam logic [10:0]      MIN_CNT  = 11'(MIN_LEN);

    state_t           r_state;
    state_t           w_next;
    logic [10:0]      r_idx;
    logic [31:0]      r_sof;
    logic [31:0]      r_ts;
    logic [15:0]      r_seq;
    logic [15:0]      r_etype;
    logic [TMO_W-1:0] r_tmo;
    logic             r_delay_valid;
    logic [31:0]      r_delay_value;
    logic [15:0]      r_delay_seq;
    logic [15:0]      r_good_count;
    logic [15:0]      r_bad_count;
    logic [15:0]      r_timeout_count;

    logic        w_start;
    logic        w_wait_enter;
    logic        w_tmo_inc;
    logic        w_tmo_hit;
    logic        w_report;
    logic        w_bad_inc;
    logic        w_match;
    logic        w_byte_en;
    logic [10:0] w_pos;
    logic        w_in_eth;
    logic        w_in_ts;
    logic        w_in_seq;
    logic [31:0] w_ts_base;
    logic [15:0] w_seq_base;
    logic [15:0] w_eth_base;

    assign w_match = (r_etype == ETHERTYPE) && (r_idx >= MIN_CNT);

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_wait_enter = 1'b0;
        w_tmo_inc    = 1'b0;
        w_tmo_hit    = 1'b0;
        w_report     = 1'b0;
        w_bad_inc    = 1'b0;
        case (r_state)
            ST_SYNC: if (!mac.mac_rx_dvld) w_next = ST_IDLE;
            ST_IDLE: begin
                if (mac.mac_rx_dvld) begin
                    w_start = 1'b1;
                    w_next  = ST_DATA;
                end
            end
            ST_DATA, ST_WAIT_STATUS: begin
                // Status resolution is shared: end of data with status, or status while waiting.
                if (r_state == ST_DATA && mac.mac_rx_dvld) begin
                    w_next = ST_DATA;
                end else if (mac.mac_rx_badframe) begin
                    w_bad_inc = 1'b1;
                    w_next    = ST_IDLE;
                end else if (mac.mac_rx_goodframe) begin
                    w_report = w_match;
                    w_next   = w_match ? ST_REPORT : ST_IDLE;
                end else if (r_state == ST_DATA) begin
                    w_wait_enter = 1'b1;
                    w_next       = ST_WAIT_STATUS;
                end else if (mac.mac_rx_dvld) begin
                    w_tmo_hit = 1'b1;
                    w_start   = 1'b1;
                    w_next    = ST_DATA;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_hit = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_REPORT: begin
                w_start = mac.mac_rx_dvld;
                w_next  = mac.mac_rx_dvld ? ST_DATA : ST_IDLE;
            end
            default: w_next = ST_SYNC;
        endcase
    end

    assign w_pos      = w_start ? '0 : r_idx;
    assign w_byte_en  = w_start || (r_state == ST_DATA && mac.mac_rx_dvld && r_idx != IDX_MAX);
    assign w_in_eth   = (w_pos >= ETH_LO) && (w_pos < ETH_HI);
    assign w_in_ts    = (w_pos >= TS_LO) && (w_pos < TS_HI);
    assign w_in_seq   = (w_pos >= SEQ_LO) && (w_pos < SEQ_HI);
    assign w_ts_base  = w_start ? '0 : r_ts;
    assign w_seq_base = w_start ? '0 : r_seq;
    assign w_eth_base = w_start ? '0 : r_etype;

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_state         <= ST_SYNC;
            r_idx           <= '0;
            r_sof           <= '0;
            r_ts            <= '0;
            r_seq           <= '0;
            r_etype         <= '0;
            r_tmo           <= '0;
            r_delay_valid   <= 1'b0;
            r_delay_value   <= '0;
            r_delay_seq     <= '0;
            r_good_count    <= '0;
            r_bad_count     <= '0;
            r_timeout_count <= '0;
        end else begin
            r_state       <= w_next;
            r_delay_valid <= w_report;
            if (w_start) r_sof <= now_time;
            if (w_byte_en) begin
                r_idx   <= w_start ? 11'd1 : r_idx + 11'd1;
                r_ts    <= w_in_ts  ? {w_ts_base[23:0], mac.mac_rx_data}  : w_ts_base;
                r_seq   <= w_in_seq ? {w_seq_base[7:0], mac.mac_rx_data}  : w_seq_base;
                r_etype <= w_in_eth ? {w_eth_base[7:0], mac.mac_rx_data}  : w_eth_base;
            end
            if (w_wait_enter)   r_tmo <= '0;
            else if (w_tmo_inc) r_tmo <= r_tmo + 1'b1;
            // Results load on the resolving edge so delay_valid lines up with the REPORT cycle.
            if (w_report) begin
                r_delay_value <= r_sof - r_ts;
                r_delay_seq   <= r_seq;
                if (r_good_count != '1) r_good_count <= r_good_count + 16'd1;
            end
            if (w_bad_inc && r_bad_count != '1)         r_bad_count     <= r_bad_count + 16'd1;
            if (w_tmo_hit && r_timeout_count != '1)     r_timeout_count <= r_timeout_count + 16'd1;
        end
    end

    assign delay_valid   = r_delay_valid;
    assign delay_value   = r_delay_value;
    assign delay_seq     = r_delay_seq;
    assign good_count    = r_good_count;
    assign bad_count     = r_bad_count;
    assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_rx_delay_meter.sv
// Directed bench for rx_delay_meter: frames are driven byte by byte and results
// compared against hand-computed delays, sequence numbers and counter values.
module tb_rx_delay_meter;

    logic        rx_clk = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] now_time = '0;
    logic        delay_valid;
    logic [31:0] delay_value;
    logic [15:0] delay_seq;
    logic [15:0] good_count;
    logic [15:0] bad_count;
    logic [15:0] timeout_count;

    int checks = 0;
    int errors = 0;

    rx_delay_meter_if bus ();

    rx_delay_meter dut (
        .rx_clk        (rx_clk),
        .reset         (reset),
        .now_time      (now_time),
        .mac           (bus),
        .delay_valid   (delay_valid),
        .delay_value   (delay_value),
        .delay_seq     (delay_seq),
        .good_count    (good_count),
        .bad_count     (bad_count),
        .timeout_count (timeout_count)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic step();
        @(posedge rx_clk);
        #1;
    endtask

    function automatic logic [7:0] frame_byte(input int i, input logic [15:0] et,
                                              input logic [31:0] ts, input logic [15:0] sq);
        logic [7:0] b;
        b = 8'(i);
        if (i == 12) b = et[15:8];
        if (i == 13) b = et[7:0];
        if (i >= 14 && i <= 17) b = ts[8*(17-i) +: 8];
        if (i == 18) b = sq[15:8];
        if (i == 19) b = sq[7:0];
        return b;
    endfunction

    // Drives len bytes back to back; now_time = t0 at byte 0. Leaves dvld low afterwards.
    task automatic send_frame(input int len, input logic [15:0] et, input logic [31:0] ts,
                              input logic [15:0] sq, input logic [31:0] t0);
        for (int i = 0; i < len; i++) begin
            bus.mac_rx_dvld = 1'b1;
            bus.mac_rx_data = frame_byte(i, et, ts, sq);
            now_time        = t0 + 32'(i);
            step();
        end
        bus.mac_rx_dvld = 1'b0;
        bus.mac_rx_data = '0;
    endtask

    task automatic pulse_good();
        bus.mac_rx_goodframe = 1'b1;
        step();
        bus.mac_rx_goodframe = 1'b0;
    endtask

    task automatic test_reset();
        bus.mac_rx_data = '0; bus.mac_rx_dvld = 1'b0;
        bus.mac_rx_goodframe = 1'b0; bus.mac_rx_badframe = 1'b0;
        reset = 1'b1;
        step(); step();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0d expected 0", delay_valid); end
        checks++; if (delay_value !== 32'd0) begin errors++; $display("FAIL rst_value: got %h expected 0", delay_value); end
        checks++; if (delay_seq !== 16'd0) begin errors++; $display("FAIL rst_seq: got %h expected 0", delay_seq); end
        checks++; if (good_count !== 16'd0) begin errors++; $display("FAIL rst_good: got %0d expected 0", good_count); end
        checks++; if (bad_count !== 16'd0) begin errors++; $display("FAIL rst_bad: got %0d expected 0", bad_count); end
        checks++; if (timeout_count !== 16'd0) begin errors++; $display("FAIL rst_tmo: got %0d expected 0", timeout_count); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_filter();
        send_frame(64, 16'h0800, 32'h0000_0100, 16'h0001, 32'd500);
        pulse_good();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL filt_etype_valid: got %0d expected 0", delay_valid); end
        step();
        send_frame(19, 16'h88B5, 32'h0000_0100, 16'h0002, 32'd600);
        pulse_good();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL filt_runt_valid: got %0d expected 0", delay_valid); end
        step();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL filt_runt_valid2: got %0d expected 0", delay_valid); end
        checks++; if ({good_count, bad_count, timeout_count} !== 48'd0)
            begin errors++; $display("FAIL filt_counters: got %h expected 0", {good_count, bad_count, timeout_count}); end
    endtask

    task automatic test_good();
        send_frame(64, 16'h88B5, 32'h0000_03B6, 16'h0007, 32'd1000);
        step();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL good_early: got %0d expected 0", delay_valid); end
        pulse_good();
        checks++; if (delay_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %0d expected 1", delay_valid); end
        checks++; if (delay_value !== 32'd50) begin errors++; $display("FAIL good_value: got %0d expected 50", delay_value); end
        checks++; if (delay_seq !== 16'd7) begin errors++; $display("FAIL good_seq: got %0d expected 7", delay_seq); end
        checks++; if (good_count !== 16'd1) begin errors++; $display("FAIL good_count: got %0d expected 1", good_count); end
        step();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL good_pulse_len: got %0d expected 0", delay_valid); end
        checks++; if (delay_value !== 32'd50) begin errors++; $display("FAIL good_hold: got %0d expected 50", delay_value); end
    endtask

    task automatic test_min_len();
        send_frame(20, 16'h88B5, 32'd100, 16'h1234, 32'd300);
        pulse_good();
        checks++; if (delay_valid !== 1'b1) begin errors++; $display("FAIL minlen_valid: got %0d expected 1", delay_valid); end
        checks++; if (delay_value !== 32'd200) begin errors++; $display("FAIL minlen_value: got %0d expected 200", delay_value); end
        checks++; if (delay_seq !== 16'h1234) begin errors++; $display("FAIL minlen_seq: got %h expected 1234", delay_seq); end
        checks++; if (good_count !== 16'd2) begin errors++; $display("FAIL minlen_count: got %0d expected 2", good_count); end
        step();
    endtask

    task automatic test_wrap();
        send_frame(24, 16'h88B5, 32'hFFFF_FFF0, 16'h00AA, 32'h0000_0010);
        pulse_good();
        checks++; if (delay_value !== 32'h20) begin errors++; $display("FAIL wrap_value: got %h expected 20", delay_value); end
        checks++; if (delay_seq !== 16'h00AA) begin errors++; $display("FAIL wrap_seq: got %h expected 00aa", delay_seq); end
        checks++; if (good_count !== 16'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", good_count); end
        step();
    endtask

    task automatic test_back_to_back();
        send_frame(32, 16'h88B5, 32'd5, 16'd1, 32'd105);
        pulse_good();
        checks++; if (delay_value !== 32'd100) begin errors++; $display("FAIL b2b_a_value: got %0d expected 100", delay_value); end
        step();
        send_frame(32, 16'h88B5, 32'd1000, 16'd2, 32'd1500);
        pulse_good();
        checks++; if (delay_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid: got %0d expected 1", delay_valid); end
        checks++; if (delay_value !== 32'd500) begin errors++; $display("FAIL b2b_b_value: got %0d expected 500", delay_value); end
        checks++; if (delay_seq !== 16'd2) begin errors++; $display("FAIL b2b_b_seq: got %0d expected 2", delay_seq); end
        // Next frame's byte 0 lands in the REPORT cycle.
        send_frame(24, 16'h88B5, 32'h100, 16'd3, 32'h300);
        pulse_good();
        checks++; if (delay_value !== 32'h200) begin errors++; $display("FAIL b2b_c_value: got %h expected 200", delay_value); end
        checks++; if (delay_seq !== 16'd3) begin errors++; $display("FAIL b2b_c_seq: got %0d expected 3", delay_seq); end
        checks++; if (good_count !== 16'd6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", good_count); end
        step();
    endtask

    task automatic test_bad();
        send_frame(30, 16'h88B5, 32'd10, 16'd4, 32'd90);
        bus.mac_rx_badframe = 1'b1;
        step();
        bus.mac_rx_badframe = 1'b0;
        checks++; if (bad_count !== 16'd1) begin errors++; $display("FAIL bad_count1: got %0d expected 1", bad_count); end
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL bad_valid1: got %0d expected 0", delay_valid); end
        step();
        send_frame(30, 16'h88B5, 32'd10, 16'd5, 32'd90);
        step();
        bus.mac_rx_goodframe = 1'b1; bus.mac_rx_badframe = 1'b1;
        step();
        bus.mac_rx_goodframe = 1'b0; bus.mac_rx_badframe = 1'b0;
        checks++; if (bad_count !== 16'd2) begin errors++; $display("FAIL bad_count2: got %0d expected 2", bad_count); end
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL bad_valid2: got %0d expected 0", delay_valid); end
        checks++; if (good_count !== 16'd6) begin errors++; $display("FAIL bad_good_count: got %0d expected 6", good_count); end
        step();
    endtask

    task automatic test_timeout();
        send_frame(24, 16'h88B5, 32'd1, 16'd8, 32'd2);
        for (int k = 0; k < 16; k++) step();
        checks++; if (timeout_count !== 16'd0) begin errors++; $display("FAIL tmo_early: got %0d expected 0", timeout_count); end
        step();
        checks++; if (timeout_count !== 16'd1) begin errors++; $display("FAIL tmo_count1: got %0d expected 1", timeout_count); end
        send_frame(24, 16'h88B5, 32'd1990, 16'd9, 32'd2000);
        for (int k = 0; k < 5; k++) step();
        send_frame(24, 16'h88B5, 32'd2900, 16'd10, 32'd3000);
        checks++; if (timeout_count !== 16'd2) begin errors++; $display("FAIL tmo_count2: got %0d expected 2", timeout_count); end
        pulse_good();
        checks++; if (delay_valid !== 1'b1) begin errors++; $display("FAIL tmo_reentry_valid: got %0d expected 1", delay_valid); end
        checks++; if (delay_value !== 32'd100) begin errors++; $display("FAIL tmo_reentry_value: got %0d expected 100", delay_value); end
        checks++; if (delay_seq !== 16'd10) begin errors++; $display("FAIL tmo_reentry_seq: got %0d expected 10", delay_seq); end
        checks++; if (good_count !== 16'd7) begin errors++; $display("FAIL tmo_good_count: got %0d expected 7", good_count); end
        step();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 64; i++) begin
            bus.mac_rx_dvld = 1'b1;
            bus.mac_rx_data = frame_byte(i, 16'h88B5, 32'd10, 16'h0055);
            now_time        = 32'd50 + 32'(i);
            reset           = (i == 30);
            step();
            if (i == 30) begin
                checks++; if ({delay_valid, delay_value, delay_seq} !== 49'd0)
                    begin errors++; $display("FAIL midrst_outputs: got %h expected 0", {delay_valid, delay_value, delay_seq}); end
                checks++; if ({good_count, bad_count, timeout_count} !== 48'd0)
                    begin errors++; $display("FAIL midrst_counters: got %h expected 0", {good_count, bad_count, timeout_count}); end
            end
        end
        reset = 1'b0;
        bus.mac_rx_dvld = 1'b0;
        pulse_good();
        checks++; if (delay_valid !== 1'b0) begin errors++; $display("FAIL midrst_tail_valid: got %0d expected 0", delay_valid); end
        step();
        checks++; if (good_count !== 16'd0) begin errors++; $display("FAIL midrst_tail_count: got %0d expected 0", good_count); end
        send_frame(24, 16'h88B5, 32'h40, 16'h0066, 32'h80);
        pulse_good();
        checks++; if (delay_value !== 32'h40) begin errors++; $display("FAIL midrst_next_value: got %h expected 40", delay_value); end
        checks++; if (delay_seq !== 16'h0066) begin errors++; $display("FAIL midrst_next_seq: got %h expected 0066", delay_seq); end
        checks++; if (good_count !== 16'd1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", good_count); end
        step();
    endtask

    task automatic test_saturation();
        force dut.r_bad_count = 16'hFFFD;
        step();
        release dut.r_bad_count;
        step();
        checks++; if (bad_count !== 16'hFFFD) begin errors++; $display("FAIL sat_preset: got %h expected fffd", bad_count); end
        for (int n = 0; n < 3; n++) begin
            bus.mac_rx_dvld = 1'b1;
            bus.mac_rx_data = 8'h00;
            step();
            bus.mac_rx_dvld = 1'b0;
            bus.mac_rx_badframe = 1'b1;
            step();
            bus.mac_rx_badframe = 1'b0;
            checks++; if (bad_count !== ((n == 0) ? 16'hFFFE : 16'hFFFF))
                begin errors++; $display("FAIL sat_bad_%0d: got %h expected %h", n, bad_count, (n == 0) ? 16'hFFFE : 16'hFFFF); end
        end
    endtask

    initial begin
        test_reset();
        test_filter();
        test_good();
        test_min_len();
        test_wrap();
        test_back_to_back();
        test_bad();
        test_timeout();
        test_reset_midframe();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_delay_meter.md
# rx_delay_meter

Receive-side measurement stage on the MAC RX byte stream in `rx_clk`, alongside the frame catcher. It parses each received test frame and extracts the 32-bit transmit timestamp and 16-bit sequence number. On a good frame it reports the one-way delay: start-of-frame local time minus the embedded timestamp. It also keeps saturating good, bad and timeout frame counters for the delay tester's readout logic.

## Interface
- `ETHERTYPE`, 16'h88B5: test-frame EtherType, matched at bytes 12–13, big-endian.
- `TS_OFFSET`, 14: byte index of the 4-byte big-endian TX timestamp.
- `SEQ_OFFSET`, 18: byte index of the 2-byte big-endian sequence number.
- `MIN_LEN`, 20: minimum byte count for a frame to be reported.
- `STATUS_TIMEOUT`, 16: maximum number of cycles to wait for good/bad status after the data ends.

Ports:
- `rx_clk`  in  1  the only clock.
- `reset`  in  1  reset, synchronous, active-high.
- `now_time`  in  32  free-running local time, already in `rx_clk` domain.
- `mac_rx_data`  in  8  RX byte.
- `mac_rx_dvld`  in  1  byte valid; high for the whole frame, no gaps.
- `mac_rx_goodframe`  in  1  one-cycle good-status pulse.
- `mac_rx_badframe`  in  1  one-cycle bad-status pulse.
- `delay_valid`  out  1  one-cycle result pulse.
- `delay_value`  out  32  delay result; held between pulses.
- `delay_seq`  out  16  sequence number of the reported frame; held between pulses.
- `good_count`  out  16  frames reported, saturating.
- `bad_count`  out  16  badframe-terminated frames, saturating.
- `timeout_count`  out  16  frames with missing status, saturating.

## Operation
- States: SYNC, IDLE, DATA, WAIT_STATUS, REPORT.
- SYNC: entered on reset. Stay while `mac_rx_dvld`=1, so a frame in progress at reset is never caught. Go to IDLE when `mac_rx_dvld`=0.
- IDLE: `mac_rx_dvld`=1 → DATA.
  - That cycle is byte 0: latch `now_time` into `sof_time` and capture the byte.
- DATA: each valid byte increments an 11-bit byte index, which saturates at 2047.
  - Bytes 12–13 are compared against `ETHERTYPE`.
  - Bytes at `TS_OFFSET`..+3 and `SEQ_OFFSET`..+1 are shifted into the timestamp and sequence registers, MSB first.
  - Bytes beyond saturation are ignored.
- DATA with `mac_rx_dvld`=0: frame ended; byte count = index.
  - If good or bad status is asserted in the same cycle, resolve immediately (rules below).
  - Otherwise go to WAIT_STATUS with the timeout counter cleared.
- Resolution:
  - `mac_rx_badframe`=1, including when asserted together with good: `bad_count`+1 → IDLE.
  - `mac_rx_goodframe`=1, EtherType matched and count ≥ `MIN_LEN` → REPORT.
  - `mac_rx_goodframe`=1 otherwise (non-test or runt frame): silently → IDLE; no counter changes.
- WAIT_STATUS:
  - The timeout counter increments every cycle without status.
  - Reaching `STATUS_TIMEOUT`: `timeout_count`+1 → IDLE.
  - If `mac_rx_dvld` rises here: `timeout_count`+1, then treat that cycle as byte 0 of a new frame → DATA.
- REPORT (one cycle):
  - `delay_value` = `sof_time` − timestamp, modulo 2^32, so wrap of `now_time` is handled.
  - Load `delay_seq`, pulse `delay_valid`, `good_count`+1 → IDLE.
  - If `mac_rx_dvld`=1 in the REPORT cycle, that cycle is byte 0 of the next frame → DATA.
- Counters hold at 16'hFFFF and never wrap.

## Timing
- Reset values:
  - all outputs 0: `delay_valid`, `delay_value`, `delay_seq`, all three counters;
  - state SYNC, internal registers 0.
- Reset asserted mid-frame: outputs clear on the next edge; any partial frame is discarded.
- `delay_valid` is registered and rises exactly 1 cycle after the cycle in which `mac_rx_goodframe` is sampled.
- `delay_value` and `delay_seq` change only in the cycle that `delay_valid` is high.
- Each counter updates 1 cycle after its resolving condition.
- A minimal back-to-back gap is supported with no frame lost: status in the first dvld-low cycle, then new dvld 2 cycles later.

## Test plan
- Good frame: 64-byte test frame, `now_time`=1000 at byte 0, TS=0x000003B6, SEQ=0x0007, good pulse 2 cycles after the last byte → `delay_valid` 1 cycle after the pulse, `delay_value`=50, `delay_seq`=7, `good_count`=1.
- Wrap: `sof_time`=0x00000010, TS=0xFFFFFFF0 → `delay_value`=0x20.
- Bad and simultaneous status: a bad pulse, then a frame with good+bad in the same cycle → `bad_count`=2, no `delay_valid`, `good_count` unchanged.
- Timeout and re-entry:
  - no status within 16 cycles → `timeout_count`=1;
  - a second frame starting at wait cycle 5 → `timeout_count`=2, and that frame, once good, reports correctly.
- Filtering: EtherType 0x0800 good frame, and a 19-byte test frame with good status → no report, all counters 0.
- Reset mid-frame: assert `reset` at byte 30 for 1 cycle → outputs 0, the remainder of that frame is ignored (SYNC), and the next full frame reports normally.
- Saturation: force 65536 bad frames → `bad_count` stays 16'hFFFF.
